// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: in-flight slot records and FSM states.
package hazard_pkg;

  // Record address fields are sized for the widest supported register file; narrower
  // addresses are zero-extended on entry, so every comparison sees the same width.
  localparam int REC_AW = 8;

  typedef struct packed {
    logic              valid;
    logic [REC_AW-1:0] rd;
    logic [REC_AW-1:0] rs2;
    logic              wr_en;
    logic              mem_rd;
    logic              mem_wr;
  } slot_rec_t;

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    WAIT = 1'b1
  } hz_state_e;

  localparam slot_rec_t BUBBLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// ID-stage, memory-handshake and hazard-control signals between the pipeline and the hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int FWD_DEPTH          = 3,
  parameter int CNT_WIDTH          = 16
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);

  logic                          ID_valid;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs1_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rs2_addr;
  logic [REGFILE_ADDR_WIDTH-1:0] ID_Rd_addr;
  logic                          ID_RegFile_wr_en;
  logic                          ID_Mem_rd_en;
  logic                          ID_Mem_wr_en;
  logic [1:0]                    ID_ALU_source_sel;
  logic                          Flush;
  logic                          DMem_ready;
  logic [SEL_W-1:0]              ForwardA;
  logic [SEL_W-1:0]              ForwardB;
  logic [SEL_W-1:0]              ForwardM;
  logic                          Stall_ID;
  logic                          Freeze;
  logic                          Mem_timeout_err;
  logic [CNT_WIDTH-1:0]          Stall_count;

  modport master (
    output ID_valid, ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr, ID_RegFile_wr_en,
           ID_Mem_rd_en, ID_Mem_wr_en, ID_ALU_source_sel, Flush, DMem_ready,
    input  ForwardA, ForwardB, ForwardM, Stall_ID, Freeze, Mem_timeout_err, Stall_count
  );

  modport slave (
    input  ID_valid, ID_Rs1_addr, ID_Rs2_addr, ID_Rd_addr, ID_RegFile_wr_en,
           ID_Mem_rd_en, ID_Mem_wr_en, ID_ALU_source_sel, Flush, DMem_ready,
    output ForwardA, ForwardB, ForwardM, Stall_ID, Freeze, Mem_timeout_err, Stall_count
  );

endinterface

// File: rtl/hazard_slot_pipe.sv
// Shift register of in-flight destination records; slot 1 is the instruction just past ID.
module hazard_slot_pipe
  import hazard_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  hold,
  input  slot_rec_t             insert_rec,
  output slot_rec_t [DEPTH:1]   slots
);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int k = 1; k <= DEPTH; k++) slots[k] <= BUBBLE;
    end else if (!hold) begin
      slots[1] <= insert_rec;
      for (int k = 2; k <= DEPTH; k++) slots[k] <= slots[k-1];
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller: operand and store-data forwarding, load-use stalls and
// data-memory wait freezing, all derived from a private record of in-flight writers.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REGFILE_ADDR_WIDTH = 5,
  parameter int FWD_DEPTH          = 3,
  parameter int LOAD_STAGE         = 2,
  parameter int MEM_TIMEOUT        = 64,
  parameter int CNT_WIDTH          = 16
) (
  input logic               Clk,
  input logic               Reset,
  pipe_hazard_ctrl_if.slave hz
);
  localparam int SEL_W = $clog2(FWD_DEPTH + 1);
  localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [0:0] ST_RUN  = RUN;
  localparam logic [0:0] ST_WAIT = WAIT;

  slot_rec_t [FWD_DEPTH:1]       slots;
  slot_rec_t                     id_rec;
  logic [0:0]                    state;
  logic [TMO_W-1:0]              tmo_cnt;
  logic                          mem_err;
  logic [CNT_WIDTH-1:0]          stall_cnt;
  logic [SEL_W-1:0]              sel_a, sel_b, sel_m;
  logic                          lu_a, lu_b, load_use, memop, freeze, stall_id;
  logic [REGFILE_ADDR_WIDTH-1:0] id_rs1, id_rs2, id_rd;
  logic [REC_AW-1:0]             rs1_ext, rs2_ext;
  logic                          unused_slot_bits;

  function automatic logic fwd_match(slot_rec_t s, logic [REC_AW-1:0] rs);
    return s.valid && s.wr_en && (s.rd != '0) && (s.rd == rs);
  endfunction

  assign id_rs1  = hz.ID_Rs1_addr;
  assign id_rs2  = hz.ID_Rs2_addr;
  assign id_rd   = hz.ID_Rd_addr;
  assign rs1_ext = REC_AW'(id_rs1);
  assign rs2_ext = REC_AW'(id_rs2);

  // Scanning oldest to youngest lets the youngest match overwrite; a too-young load yields load-use.
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    lu_a  = 1'b0;
    lu_b  = 1'b0;
    for (int k = FWD_DEPTH; k >= 1; k--) begin
      if (fwd_match(slots[k], rs1_ext)) begin
        lu_a  = slots[k].mem_rd && (k < LOAD_STAGE);
        sel_a = lu_a ? '0 : SEL_W'(k);
      end
      if (fwd_match(slots[k], rs2_ext)) begin
        lu_b  = slots[k].mem_rd && (k < LOAD_STAGE);
        sel_b = lu_b ? '0 : SEL_W'(k);
      end
    end
  end

  always_comb begin
    sel_m = '0;
    for (int k = FWD_DEPTH; k >= 2; k--) begin
      if (fwd_match(slots[k], slots[1].rs2) && (!slots[k].mem_rd || k >= LOAD_STAGE))
        sel_m = SEL_W'(k);
    end
  end

  // An operand that is not read from the register file can never cause a load-use stall.
  assign load_use = (lu_a && !hz.ID_ALU_source_sel[1]) || (lu_b && !hz.ID_ALU_source_sel[0]);
  assign memop    = slots[LOAD_STAGE].valid && (slots[LOAD_STAGE].mem_rd || slots[LOAD_STAGE].mem_wr);
  assign freeze   = (state == ST_RUN) ? (memop && !hz.DMem_ready) : !hz.DMem_ready;
  assign stall_id = load_use && hz.ID_valid && !hz.Flush && !freeze;

  always_comb begin
    id_rec = BUBBLE;
    if (hz.ID_valid && !stall_id && !hz.Flush) begin
      id_rec.valid  = 1'b1;
      id_rec.rd     = REC_AW'(id_rd);
      id_rec.rs2    = rs2_ext;
      id_rec.wr_en  = hz.ID_RegFile_wr_en;
      id_rec.mem_rd = hz.ID_Mem_rd_en;
      id_rec.mem_wr = hz.ID_Mem_wr_en;
    end
  end

  hazard_slot_pipe #(.DEPTH(FWD_DEPTH)) u_slots (
    .clk        (Clk),
    .reset      (Reset),
    .hold       (freeze),
    .insert_rec (id_rec),
    .slots      (slots)
  );

  // The WAIT counter stops at the limit so the error stays sticky without wrapping.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state     <= ST_RUN;
      tmo_cnt   <= '0;
      mem_err   <= 1'b0;
      stall_cnt <= '0;
    end else begin
      if (stall_id && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_WIDTH'(1);
      if (state == ST_RUN) begin
        if (freeze) begin
          state   <= ST_WAIT;
          tmo_cnt <= TMO_W'(1);
          if (MEM_TIMEOUT <= 1) mem_err <= 1'b1;
        end
      end else if (hz.DMem_ready) begin
        state <= ST_RUN;
      end else if (tmo_cnt < TMO_W'(MEM_TIMEOUT)) begin
        tmo_cnt <= tmo_cnt + TMO_W'(1);
        if (tmo_cnt == TMO_W'(MEM_TIMEOUT - 1)) mem_err <= 1'b1;
      end
    end
  end

  assign hz.ForwardA        = (hz.ID_valid && !hz.ID_ALU_source_sel[1]) ? sel_a : '0;
  assign hz.ForwardB        = (hz.ID_valid && !hz.ID_ALU_source_sel[0]) ? sel_b : '0;
  assign hz.ForwardM        = (slots[1].valid && slots[1].mem_wr) ? sel_m : '0;
  assign hz.Stall_ID        = stall_id;
  assign hz.Freeze          = freeze;
  assign hz.Mem_timeout_err = mem_err;
  assign hz.Stall_count     = stall_cnt;

  assign unused_slot_bits = ^slots;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: each scenario queues expected output vectors
// as it drives ID/memory stimulus and pops them when the outputs are sampled.
module tb_pipe_hazard_ctrl;
  localparam int AW = 5, DEPTH = 3, LSTAGE = 2, TMO = 4, CW = 16;

  typedef struct {
    string       tag;
    logic [24:0] v;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_cmp = 0;
  int   n_bad = 0;
  int   exp_stalls = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REGFILE_ADDR_WIDTH(AW), .FWD_DEPTH(DEPTH), .CNT_WIDTH(CW)) hz ();

  pipe_hazard_ctrl #(
    .REGFILE_ADDR_WIDTH (AW),
    .FWD_DEPTH          (DEPTH),
    .LOAD_STAGE         (LSTAGE),
    .MEM_TIMEOUT        (TMO),
    .CNT_WIDTH          (CW)
  ) dut (
    .Clk   (clk),
    .Reset (reset),
    .hz    (hz)
  );

  // Output vector layout: {ForwardA, ForwardB, ForwardM, Stall_ID, Freeze, Mem_timeout_err, Stall_count}
  function automatic logic [24:0] mk(int fa, int fb, int fm, logic st, logic fz, logic er, int cnt);
    return {fa[1:0], fb[1:0], fm[1:0], st, fz, er, cnt[15:0]};
  endfunction

  function automatic logic [24:0] got();
    return {hz.ForwardA, hz.ForwardB, hz.ForwardM, hz.Stall_ID, hz.Freeze, hz.Mem_timeout_err, hz.Stall_count};
  endfunction

  function automatic string show(logic [24:0] v);
    return $sformatf("fa=%0d fb=%0d fm=%0d stall=%0b frz=%0b err=%0b cnt=%0d",
                     v[24:23], v[22:21], v[20:19], v[18], v[17], v[16], v[15:0]);
  endfunction

  task automatic set_id(logic v, int rs1, int rs2, int rd, logic wr, logic mr, logic mw, logic [1:0] sel);
    hz.ID_valid          = v;
    hz.ID_Rs1_addr       = AW'(rs1);
    hz.ID_Rs2_addr       = AW'(rs2);
    hz.ID_Rd_addr        = AW'(rd);
    hz.ID_RegFile_wr_en  = wr;
    hz.ID_Mem_rd_en      = mr;
    hz.ID_Mem_wr_en      = mw;
    hz.ID_ALU_source_sel = sel;
  endtask

  task automatic idle();
    set_id(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(int n);
    idle();
    repeat (n) next_cycle();
  endtask

  task automatic test_reset();
    exp_t e;
    reset = 1'b1;
    hz.Flush = 1'b0;
    hz.DMem_ready = 1'b1;
    idle();
    next_cycle();
    next_cycle();
    reset = 1'b0;
    exp_q.push_back('{"reset_outputs", mk(0, 0, 0, 0, 0, 0, 0)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
  endtask

  task automatic test_back_to_back();
    exp_t e;
    set_id(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 2'b00);
    next_cycle();
    set_id(1'b1, 0, 0, 5, 1'b1, 1'b0, 1'b0, 2'b00);
    next_cycle();
    set_id(1'b1, 5, 5, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    exp_q.push_back('{"bb_youngest", mk(1, 1, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    hz.ID_ALU_source_sel = 2'b11;
    exp_q.push_back('{"bb_sel11", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    #1; e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    hz.ID_ALU_source_sel = 2'b01;
    exp_q.push_back('{"bb_sel01", mk(1, 0, 0, 0, 0, 0, exp_stalls)});
    #1; e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    hz.ID_ALU_source_sel = 2'b00;
    hz.ID_valid = 1'b0;
    exp_q.push_back('{"bb_id_invalid", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    #1; e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    hz.ID_valid = 1'b1;
    next_cycle();
    // From here slot records with rd=0 and wr_en=1 enter the pipe and must never forward.
    set_id(1'b1, 5, 0, 0, 1'b1, 1'b0, 1'b0, 2'b00);
    exp_q.push_back('{"bb_slot2", mk(2, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    exp_q.push_back('{"bb_slot3", mk(3, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    set_id(1'b1, 0, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    exp_q.push_back('{"bb_rd0_ignored", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    drain(3);
  endtask

  task automatic test_load_use();
    exp_t e;
    set_id(1'b1, 0, 0, 7, 1'b1, 1'b1, 1'b0, 2'b01);
    next_cycle();
    set_id(1'b1, 7, 3, 3, 1'b1, 1'b0, 1'b0, 2'b00);
    exp_q.push_back('{"lu_stall", mk(0, 0, 0, 1, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    exp_stalls++;
    exp_q.push_back('{"lu_fwd_slot2", mk(2, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    drain(3);
  endtask

  task automatic test_store_fwd();
    exp_t e;
    set_id(1'b1, 0, 0, 9, 1'b1, 1'b1, 1'b0, 2'b01);
    next_cycle();
    set_id(1'b1, 0, 9, 0, 1'b0, 1'b0, 1'b1, 2'b01);
    exp_q.push_back('{"st_no_stall", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    idle();
    exp_q.push_back('{"st_fwdm_slot2", mk(0, 0, 2, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    exp_q.push_back('{"st_fwdm_clear", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    drain(3);
  endtask

  task automatic test_flush_vs_stall();
    exp_t e;
    set_id(1'b1, 0, 0, 8, 1'b1, 1'b1, 1'b0, 2'b01);
    next_cycle();
    set_id(1'b1, 8, 0, 10, 1'b1, 1'b0, 1'b0, 2'b00);
    hz.Flush = 1'b1;
    exp_q.push_back('{"fl_no_stall", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    hz.Flush = 1'b0;
    set_id(1'b1, 8, 10, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    exp_q.push_back('{"fl_bubble", mk(2, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    drain(3);
  endtask

  task automatic test_mem_wait();
    exp_t e;
    set_id(1'b1, 0, 0, 4, 1'b1, 1'b1, 1'b0, 2'b01);
    next_cycle();
    set_id(1'b1, 0, 0, 6, 1'b1, 1'b0, 1'b0, 2'b00);
    next_cycle();
    set_id(1'b1, 4, 6, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    hz.DMem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back('{$sformatf("mw_freeze_%0d", i), mk(2, 1, 0, 0, 1, 0, exp_stalls)});
      @(negedge clk); e = exp_q.pop_front(); n_cmp++;
      if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
      next_cycle();
    end
    hz.DMem_ready = 1'b1;
    exp_q.push_back('{"mw_release", mk(2, 1, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    exp_q.push_back('{"mw_advanced", mk(3, 2, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
    drain(3);
  endtask

  task automatic test_timeout();
    exp_t e;
    set_id(1'b1, 0, 0, 2, 1'b1, 1'b1, 1'b0, 2'b01);
    next_cycle();
    idle();
    next_cycle();
    hz.DMem_ready = 1'b0;
    exp_q.push_back('{"tmo_enter", mk(0, 0, 0, 0, 1, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    repeat (3) next_cycle();
    exp_q.push_back('{"tmo_wait3_no_err", mk(0, 0, 0, 0, 1, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    repeat (2) next_cycle();
    exp_q.push_back('{"tmo_err_set", mk(0, 0, 0, 0, 1, 1, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    next_cycle();
  endtask

  task automatic test_reset_mid_wait();
    exp_t e;
    reset = 1'b1;
    set_id(1'b1, 2, 0, 0, 1'b0, 1'b0, 1'b0, 2'b00);
    next_cycle();
    reset = 1'b0;
    exp_stalls = 0;
    exp_q.push_back('{"rst_mid_wait", mk(0, 0, 0, 0, 0, 0, exp_stalls)});
    @(negedge clk); e = exp_q.pop_front(); n_cmp++;
    if (got() !== e.v) begin n_bad++; $display("FAIL %s: got %s, expected %s", e.tag, show(got()), show(e.v)); end
    hz.DMem_ready = 1'b1;
    next_cycle();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_load_use();
    test_store_fwd();
    test_flush_vs_stall();
    test_mem_wait();
    test_timeout();
    test_reset_mid_wait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required to have finished", $time);
    $fatal(1, "[TB] timeout");
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Parametrised successor to the pipeline forwarding unit. It combines operand forwarding, store-data forwarding, load-use stall generation and data-memory wait freezing in one block. It keeps its own shift register of in-flight destination records, FWD_DEPTH slots deep, behind the ID stage. Forwarding selects and stall controls are computed from those records against the instruction currently in ID.

Parameters:
REGFILE_ADDR_WIDTH, 5, register address width
FWD_DEPTH, 3, number of tracked stages ahead of ID (slot 1 = EX ... slot FWD_DEPTH); legal range 2..7
LOAD_STAGE, 2, first slot at which load data is forwardable; 2 <= LOAD_STAGE <= FWD_DEPTH
MEM_TIMEOUT, 64, cycles in WAIT before Mem_timeout_err sets
CNT_WIDTH, 16, width of Stall_count
SEL_W, $clog2(FWD_DEPTH+1), derived localparam, forwarding select width

Ports:
Clk  in  1  clock, rising edge
Reset  in  1  synchronous, active-high
ID_valid  in  1  ID holds a real instruction
ID_Rs1_addr  in  REGFILE_ADDR_WIDTH  ID source 1
ID_Rs2_addr  in  REGFILE_ADDR_WIDTH  ID source 2
ID_Rd_addr  in  REGFILE_ADDR_WIDTH  ID destination
ID_RegFile_wr_en  in  1  ID writes Rd
ID_Mem_rd_en  in  1  ID is a load
ID_Mem_wr_en  in  1  ID is a store
ID_ALU_source_sel  in  2  bit1: op1 not a register; bit0: op2 immediate
Flush  in  1  branch/jump resolved in slot 1; kill ID
DMem_ready  in  1  data memory completes the op presented this cycle
ForwardA  out  SEL_W  op1 source: 0 = regfile, k = slot k result
ForwardB  out  SEL_W  op2 source, same encoding
ForwardM  out  SEL_W  store data for store in slot 1: 0 = pipeline value, k = slot k (k >= 2)
Stall_ID  out  1  hold PC and IF/ID; bubble into slot 1
Freeze  out  1  hold entire pipeline, including this block
Mem_timeout_err  out  1  sticky, WAIT exceeded MEM_TIMEOUT
Stall_count  out  CNT_WIDTH  saturating count of load-use bubble cycles

Behaviour:
- Reset (synchronous, active-high; the next edge with Reset=1 applies it, also mid-operation):
  - all slots become bubbles (valid=0, wr_en=0, mem flags 0);
  - FSM goes to RUN; timeout counter, Stall_count and Mem_timeout_err clear;
  - consequently every output is 0.
- Slot record contents: valid, rd, rs2, wr_en, mem_rd, mem_wr.
- Slot advance (each edge, Freeze=0):
  - slot[k] <= slot[k-1] for k >= 2;
  - slot[1] <= bubble if Stall_ID or Flush or !ID_valid, else the ID record.
  - Freeze=1: all slots hold.
- Forward match on slot k for source rs: valid && wr_en && rd != 0 && rd == rs.
- ForwardA/ForwardB:
  - select is the lowest (youngest) matching k;
  - if the youngest match is a load with k < LOAD_STAGE, the select is 0 and the operand raises load-use;
  - ForwardA is forced 0 when ID_ALU_source_sel[1]=1; ForwardB is forced 0 when ID_ALU_source_sel[0]=1;
  - ID_valid=0 forces both 0. All selects are combinational, same cycle as ID.
- ForwardM:
  - active when slot 1 holds a store;
  - select is the lowest k in 2..FWD_DEPTH matching slot1.rs2; loads are only eligible at k >= LOAD_STAGE.
- Store data (rs2 of a store with op2 immediate) never raises load-use; it is covered by ForwardM later.
- Stall_ID = load-use && ID_valid && !Flush && !Freeze. It repeats naturally until the load reaches LOAD_STAGE (LOAD_STAGE-k cycles).
- FSM RUN / WAIT:
  - memop = slot[LOAD_STAGE].valid && (mem_rd || mem_wr).
  - RUN: Freeze = memop && !DMem_ready; if Freeze, go to WAIT and timeout counter <= 1.
  - WAIT: Freeze = !DMem_ready; DMem_ready=1 returns to RUN (slots advance that edge); otherwise the counter increments.
  - When the counter reaches MEM_TIMEOUT, Mem_timeout_err sets (sticky until Reset) and the FSM stays in WAIT.
- Simultaneous events:
  - Freeze beats Flush and stall; Flush is ignored while frozen, so upstream must hold it.
  - Flush beats Stall_ID.
- Stall_count: +1 each edge with Stall_ID=1; saturates at all-ones.

Decomposition:
- hazard_pkg:
  - slot_rec_t packed struct {valid, rd, rs2, wr_en, mem_rd, mem_wr};
  - hz_state_e {RUN, WAIT};
  - BUBBLE constant.
- One sub-module, hazard_slot_pipe: parametrised FWD_DEPTH shift register of slot_rec_t with advance/insert/hold/reset controls, exposing all slots as an array.
- Match priority, FSM and counters stay in pipe_hazard_ctrl.

Test Plan:
- Back-to-back ALU:
  - stimulus: slot1 {rd=5, wr}, slot2 {rd=5, wr}; ID rs1=5, rs2=5, sel=00;
  - required: ForwardA=1, ForwardB=1 (youngest wins); with sel=11 both 0; rd=0 in both slots -> both 0.
- Load-use, LOAD_STAGE=2:
  - stimulus: load rd=7 enters slot1; ID rs1=7;
  - required: Stall_ID=1 for exactly 1 cycle and slot1 becomes a bubble;
  - next cycle: load in slot2, ForwardA=2, Stall_ID=0; Stall_count=1.
- Store-data forward:
  - stimulus: load rd=9 in ID, then store rs2=9 with op2 immediate;
  - required: no stall; when store is in slot1 and load in slot2, ForwardM=2.
- Memory wait:
  - stimulus: load in slot2, DMem_ready=0 for 3 cycles;
  - required: Freeze=1 for 3 cycles, slots unchanged, FSM WAIT; ready=1 -> Freeze=0, advance;
  - with MEM_TIMEOUT=4 and ready held low: Mem_timeout_err=1 after 4 WAIT cycles.
- Flush vs stall:
  - stimulus: load-use condition and Flush=1 in the same cycle;
  - required: Stall_ID=0, slot1 bubble, Stall_count unchanged.
- Reset mid-WAIT:
  - stimulus: Reset=1 one cycle during WAIT with err set;
  - required: next cycle all outputs 0, FSM RUN, slots empty.
